// File: rtl/decoder_pack_stage.sv
// decoder_pack_stage: ID->EX register packing decoder fields into one control word,
// with a 2-entry skid buffer so in_ready depends only on registered state.
module decoder_pack_stage #(
    parameter int                CTRL_W      = 42,
    parameter logic [CTRL_W-1:0] BUBBLE_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        af,
    input  logic              i,
    input  logic              alu_mux_sel,
    input  logic [2:0]        shift_type,
    input  logic [4:0]        cad,
    input  logic              gp_we,
    input  logic [2:0]        gp_mux_sel,
    input  logic [3:0]        bf,
    input  logic [1:0]        pc_mux_select,
    input  logic              spr_mux_sel,
    input  logic              mem_wren,
    input  logic              mem_rren,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    output logic [CTRL_W-1:0] packed_out,
    output logic              out_valid,
    input  logic              out_ready
);
    if (CTRL_W != 42) begin : g_width_check
        $error("decoder_pack_stage: CTRL_W must equal the packed field width (42)");
    end

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t            state, state_n;
    logic [CTRL_W-1:0] main_q, skid_q, word;
    logic              accept, emit, load_main, load_skid, move_skid;

    assign word = {af, i, alu_mux_sel, shift_type, cad, gp_we, gp_mux_sel, bf,
                   pc_mux_select, spr_mux_sel, mem_wren, mem_rren, rs, rt, rd};

    assign in_ready   = state != SKID;
    assign out_valid  = state != EMPTY;
    assign packed_out = out_valid ? main_q : BUBBLE_WORD;
    // a flushed cycle never captures the incoming word
    assign accept     = in_valid & in_ready & ~flush;
    assign emit       = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) state_n = EMPTY;
        else begin
            case (state)
                EMPTY: begin
                    load_main = accept;
                    state_n   = accept ? FULL : EMPTY;
                end
                FULL: begin
                    load_main = accept & emit;
                    load_skid = accept & ~emit;
                    state_n   = (accept & ~emit) ? SKID : (~accept & emit) ? EMPTY : FULL;
                end
                SKID: begin
                    move_skid = emit;
                    state_n   = emit ? FULL : SKID;
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)      main_q <= word;
            else if (move_skid) main_q <= skid_q;
            if (load_skid) skid_q <= word;
        end
    end
endmodule

// File: tb/tb_decoder_pack_stage.sv
// tb_decoder_pack_stage: directed scenarios plus a randomized run scored against
// a two-deep FIFO model of the stage.
module tb_decoder_pack_stage;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [3:0]  af = '0, bf = '0;
    logic        i = 1'b0, alu_mux_sel = 1'b0, gp_we = 1'b0, spr_mux_sel = 1'b0;
    logic        mem_wren = 1'b0, mem_rren = 1'b0;
    logic [2:0]  shift_type = '0, gp_mux_sel = '0;
    logic [4:0]  cad = '0, rs = '0, rt = '0, rd = '0;
    logic [1:0]  pc_mux_select = '0;
    logic [41:0] packed_out;
    int checks = 0, failures = 0;

    decoder_pack_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .af(af), .i(i), .alu_mux_sel(alu_mux_sel), .shift_type(shift_type), .cad(cad),
        .gp_we(gp_we), .gp_mux_sel(gp_mux_sel), .bf(bf), .pc_mux_select(pc_mux_select),
        .spr_mux_sel(spr_mux_sel), .mem_wren(mem_wren), .mem_rren(mem_rren),
        .rs(rs), .rt(rt), .rd(rd), .packed_out(packed_out), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] pack_fields();
        return (42'(af) << 38) | (42'(i) << 37) | (42'(alu_mux_sel) << 36) |
               (42'(shift_type) << 33) | (42'(cad) << 28) | (42'(gp_we) << 27) |
               (42'(gp_mux_sel) << 24) | (42'(bf) << 20) | (42'(pc_mux_select) << 18) |
               (42'(spr_mux_sel) << 17) | (42'(mem_wren) << 16) | (42'(mem_rren) << 15) |
               (42'(rs) << 10) | (42'(rt) << 5) | 42'(rd);
    endfunction

    task automatic rand_fields();
        af = 4'($urandom); i = 1'($urandom); alu_mux_sel = 1'($urandom);
        shift_type = 3'($urandom); cad = 5'($urandom); gp_we = 1'($urandom);
        gp_mux_sel = 3'($urandom); bf = 4'($urandom); pc_mux_select = 2'($urandom);
        spr_mux_sel = 1'($urandom); mem_wren = 1'($urandom); mem_rren = 1'($urandom);
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (packed_out !== 42'h0) begin failures++; $display("FAIL reset_packed got=%h exp=0", packed_out); end
        rst = 1'b0;
    endtask

    task automatic test_pack();
        @(negedge clk);
        af = 4'hA; i = 1'b1; shift_type = 3'b101; cad = 5'd31; rs = 5'd1; rt = 5'd2; rd = 5'd3;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pack_valid got=%b exp=1", out_valid); end
        checks++; if (packed_out !== 42'h2AB_F000_0443) begin failures++; $display("FAIL pack_word got=%h exp=%h", packed_out, 42'h2AB_F000_0443); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || packed_out !== 42'h0) begin failures++; $display("FAIL pack_drain got=%b/%h exp=0/0", out_valid, packed_out); end
    endtask

    task automatic test_back_to_back();
        logic [41:0] exp [8];
        out_ready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready k=%0d got=%b exp=1", k, in_ready); end
            if (k > 0) begin
                checks++; if (out_valid !== 1'b1 || packed_out !== exp[k-1]) begin failures++; $display("FAIL b2b_word k=%0d got=%b/%h exp=1/%h", k, out_valid, packed_out, exp[k-1]); end
            end
            if (k < 8) begin rand_fields(); exp[k] = pack_fields(); in_valid = 1'b1; end
            else in_valid = 1'b0;
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_stall();
        logic [41:0] a, b, c;
        out_ready = 1'b0;
        @(negedge clk); rand_fields(); a = pack_fields(); in_valid = 1'b1;
        @(negedge clk); rand_fields(); b = pack_fields();
        checks++; if (in_ready !== 1'b1 || packed_out !== a) begin failures++; $display("FAIL stall_a got=%b/%h exp=1/%h", in_ready, packed_out, a); end
        @(negedge clk); rand_fields(); c = pack_fields();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_full_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || packed_out !== a) begin failures++; $display("FAIL stall_hold got=%b/%b/%h exp=0/1/%h", in_ready, out_valid, packed_out, a); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || packed_out !== b) begin failures++; $display("FAIL stall_b got=%b/%h exp=1/%h", in_ready, packed_out, b); end
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || packed_out !== c) begin failures++; $display("FAIL stall_c got=%b/%h exp=1/%h", out_valid, packed_out, c); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        @(negedge clk); rand_fields(); in_valid = 1'b1;
        @(negedge clk); rand_fields();
        @(negedge clk); rand_fields();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_pre_ready got=%b exp=0", in_ready); end
        flush = 1'b1;
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || packed_out !== 42'h0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_post got=%b/%h/%b exp=0/0/1", out_valid, packed_out, in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_leak k=%0d got=%b exp=0", k, out_valid); end
        end
    endtask

    task automatic test_async_reset();
        logic [41:0] d;
        out_ready = 1'b0;
        @(negedge clk); rand_fields(); in_valid = 1'b1;
        @(negedge clk); rand_fields();
        @(negedge clk); in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || packed_out !== 42'h0) begin failures++; $display("FAIL async_rst got=%b/%b/%h exp=0/1/0", out_valid, in_ready, packed_out); end
        @(negedge clk); rst = 1'b0;
        rand_fields(); d = pack_fields(); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || packed_out !== d) begin failures++; $display("FAIL async_rst_d got=%b/%h exp=1/%h", out_valid, packed_out, d); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_rst_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        logic [41:0] q [$];
        logic acc, emit;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_valid k=%0d got=%b exp=%b", k, out_valid, q.size() > 0); end
            checks++; if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rnd_ready k=%0d got=%b exp=%b", k, in_ready, q.size() < 2); end
            checks++; if (packed_out !== (q.size() > 0 ? q[0] : 42'h0)) begin failures++; $display("FAIL rnd_word k=%0d got=%h exp=%h", k, packed_out, q.size() > 0 ? q[0] : 42'h0); end
            checks++; if (!out_valid && (packed_out[27] || packed_out[16] || packed_out[15])) begin failures++; $display("FAIL rnd_bubble k=%0d got=%h exp=0", k, packed_out); end
            rand_fields();
            in_valid = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush = ($urandom_range(31) == 0);
            acc = in_valid && q.size() < 2;
            emit = q.size() > 0 && out_ready;
            if (flush) q.delete();
            else begin
                if (emit) void'(q.pop_front());
                if (acc) q.push_back(pack_fields());
            end
        end
        @(negedge clk); in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pack();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
